// File: rtl/tap_controller.sv
// IEEE 1149.1-style TAP controller with an instruction register, a bypass bit
// and a BIST run counter. It drives the boundary-scan chain and BILBO controls.
module tap_controller #(
  parameter int IR_W        = 3,
  parameter int BIST_CYCLES = 255
) (
  input  logic clock,
  input  logic rst_l,
  input  logic tms,
  input  logic tdi,
  output logic tdo,
  input  logic bsr_scan_out,
  output logic bsr_scan_in,
  output logic bsr_shift,
  output logic bsr_capture,
  output logic bsr_update,
  output logic bsr_en,
  output logic b1,
  output logic b2,
  output logic bist_done
);

  typedef enum logic [3:0] {
    TLR    = 4'd0,
    RTI    = 4'd1,
    SEL_DR = 4'd2,
    CAP_DR = 4'd3,
    SH_DR  = 4'd4,
    EX1_DR = 4'd5,
    PA_DR  = 4'd6,
    EX2_DR = 4'd7,
    UPD_DR = 4'd8,
    SEL_IR = 4'd9,
    CAP_IR = 4'd10,
    SH_IR  = 4'd11,
    EX1_IR = 4'd12,
    PA_IR  = 4'd13,
    EX2_IR = 4'd14,
    UPD_IR = 4'd15
  } tap_state_t;

  localparam logic [IR_W-1:0] OP_EXTEST  = '0;
  localparam logic [IR_W-1:0] OP_SAMPLE  = IR_W'(1);
  localparam logic [IR_W-1:0] OP_INTEST  = IR_W'(2);
  localparam logic [IR_W-1:0] OP_BIST    = IR_W'(3);
  localparam logic [IR_W-1:0] OP_BYPASS  = '1;
  localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);
  localparam logic [15:0]     BIST_MAX   = 16'(BIST_CYCLES);
  localparam logic [15:0]     BIST_LAST  = 16'(BIST_CYCLES - 1);

  tap_state_t      state, next_state;
  logic [IR_W-1:0] ir_shift;
  logic [IR_W-1:0] ir_active;
  logic            bypass_bit;
  logic [15:0]     bist_cnt;
  logic            bsr_sel;
  logic            bist_sel;
  logic            bist_run;

  always_comb begin
    next_state = TLR;
    unique case (state)
      TLR:    next_state = tms ? TLR    : RTI;
      RTI:    next_state = tms ? SEL_DR : RTI;
      SEL_DR: next_state = tms ? SEL_IR : CAP_DR;
      CAP_DR: next_state = tms ? EX1_DR : SH_DR;
      SH_DR:  next_state = tms ? EX1_DR : SH_DR;
      EX1_DR: next_state = tms ? UPD_DR : PA_DR;
      PA_DR:  next_state = tms ? EX2_DR : PA_DR;
      EX2_DR: next_state = tms ? UPD_DR : SH_DR;
      UPD_DR: next_state = tms ? SEL_DR : RTI;
      SEL_IR: next_state = tms ? TLR    : CAP_IR;
      CAP_IR: next_state = tms ? EX1_IR : SH_IR;
      SH_IR:  next_state = tms ? EX1_IR : SH_IR;
      EX1_IR: next_state = tms ? UPD_IR : PA_IR;
      PA_IR:  next_state = tms ? EX2_IR : PA_IR;
      EX2_IR: next_state = tms ? UPD_IR : SH_IR;
      UPD_IR: next_state = tms ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  assign bsr_sel  = (ir_active == OP_EXTEST) || (ir_active == OP_SAMPLE) ||
                    (ir_active == OP_INTEST);
  assign bist_sel = (ir_active == OP_BIST);
  assign bist_run = bist_sel && (state == RTI) && (bist_cnt < BIST_MAX);

  // Active IR is forced to BYPASS on the edge that enters TLR, so the
  // instruction is already BYPASS in the first TLR cycle.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      state     <= TLR;
      ir_shift  <= IR_CAPTURE;
      ir_active <= OP_BYPASS;
    end else begin
      state <= next_state;
      if (state == CAP_IR)
        ir_shift <= IR_CAPTURE;
      else if (state == SH_IR)
        ir_shift <= {tdi, ir_shift[IR_W-1:1]};
      if (next_state == TLR)
        ir_active <= OP_BYPASS;
      else if (state == UPD_IR)
        ir_active <= ir_shift;
    end
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l)
      bypass_bit <= 1'b0;
    else if (state == CAP_DR)
      bypass_bit <= 1'b0;
    else if (state == SH_DR)
      bypass_bit <= tdi;
  end

  // Done is set by the increment that reaches the limit, so leaving RTI on
  // that same edge still flags completion.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      bist_cnt  <= '0;
      bist_done <= 1'b0;
    end else begin
      if (state == UPD_IR)
        bist_cnt <= '0;
      else if (bist_run)
        bist_cnt <= bist_cnt + 16'd1;
      if ((state == UPD_IR) || (next_state == TLR))
        bist_done <= 1'b0;
      else if (bist_run && (bist_cnt == BIST_LAST))
        bist_done <= 1'b1;
    end
  end

  always_comb begin
    tdo = 1'b0;
    if (state == SH_IR)
      tdo = ir_shift[0];
    else if (state == SH_DR)
      tdo = bsr_sel ? bsr_scan_out : bypass_bit;
  end

  assign bsr_scan_in = tdi;
  assign bsr_capture = bsr_sel && ((state == CAP_DR) || (state == SH_DR));
  assign bsr_shift   = bsr_sel && (state == SH_DR);
  assign bsr_update  = bsr_sel && (state == UPD_DR);
  assign bsr_en      = (ir_active == OP_EXTEST) || (ir_active == OP_INTEST);

  always_comb begin
    b1 = 1'b1;
    b2 = 1'b1;
    if (bist_sel && (state == SH_DR)) begin
      b1 = 1'b0;
      b2 = 1'b0;
    end else if (bist_run) begin
      b2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_tap_controller.sv
// Directed scoreboard bench for tap_controller: stimulus pushes the expected
// per-cycle output vector, a negedge monitor pops and compares it.
module tb_tap_controller;

  logic clock = 1'b0;
  logic rst_l;
  logic tms;
  logic tdi;
  logic tdo;
  logic bsr_scan_out;
  logic bsr_scan_in;
  logic bsr_shift;
  logic bsr_capture;
  logic bsr_update;
  logic bsr_en;
  logic b1;
  logic b2;
  logic bist_done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      nm;
    logic [8:0] exp;
  } exp_item_t;

  exp_item_t sb[$];

  // Vector layout: {tdo, bsr_shift, bsr_capture, bsr_update, bsr_en, b1, b2, bist_done}
  localparam logic [7:0] V_N      = 8'b0000_0110;
  localparam logic [7:0] V_N_T1   = 8'b1000_0110;
  localparam logic [7:0] V_EN     = 8'b0000_1110;
  localparam logic [7:0] V_CAP    = 8'b0010_1110;
  localparam logic [7:0] V_SH0    = 8'b0110_1110;
  localparam logic [7:0] V_SH1    = 8'b1110_1110;
  localparam logic [7:0] V_UPD    = 8'b0001_1110;
  localparam logic [7:0] V_BIST   = 8'b0000_0100;
  localparam logic [7:0] V_DONE   = 8'b0000_0111;
  localparam logic [7:0] V_DONE_T = 8'b1000_0111;
  localparam logic [7:0] V_BSHIFT = 8'b0000_0001;

  tap_controller #(
    .IR_W       (3),
    .BIST_CYCLES(10)
  ) dut (
    .clock       (clock),
    .rst_l       (rst_l),
    .tms         (tms),
    .tdi         (tdi),
    .tdo         (tdo),
    .bsr_scan_out(bsr_scan_out),
    .bsr_scan_in (bsr_scan_in),
    .bsr_shift   (bsr_shift),
    .bsr_capture (bsr_capture),
    .bsr_update  (bsr_update),
    .bsr_en      (bsr_en),
    .b1          (b1),
    .b2          (b2),
    .bist_done   (bist_done)
  );

  always #5 clock = ~clock;

  // Four-cell boundary-scan chain; parallel capture loads 0110.
  logic [3:0] chain = 4'b0000;
  always @(posedge clock) begin
    if (bsr_capture)
      chain <= bsr_shift ? {bsr_scan_in, chain[3:1]} : 4'b0110;
  end
  assign bsr_scan_out = chain[0];

  task automatic cyc(input logic t, input logic d, input string nm, input logic [7:0] e);
    exp_item_t it;
    it.nm  = nm;
    it.exp = {e[7], d, e[6:0]};
    sb.push_back(it);
    tms = t;
    tdi = d;
    @(posedge clock);
    #1;
  endtask

  initial begin : monitor
    exp_item_t  it;
    logic [8:0] act;
    forever begin
      @(negedge clock);
      if (sb.size() != 0) begin
        it  = sb.pop_front();
        act = {tdo, bsr_scan_in, bsr_shift, bsr_capture, bsr_update, bsr_en, b1, b2, bist_done};
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b (tdo,si,sh,cap,upd,en,b1,b2,done)",
                   it.nm, act, it.exp);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] byp_bits;
    logic [7:0] byp_tdo;
    rst_l = 1'b0;
    tms   = 1'b1;
    tdi   = 1'b0;
    @(posedge clock);
    #1;

    // Reset values, then TLR holds under tms=1
    cyc(1, 0, "reset_vals", V_N);
    rst_l = 1'b1;
    cyc(1, 0, "tlr_hold", V_N);

    // Load EXTEST (000); IR capture 001 visible on tdo LSB-first
    cyc(0, 0, "ld_tlr", V_N);
    cyc(1, 0, "ld_rti", V_N);
    cyc(1, 0, "ld_seldr", V_N);
    cyc(0, 0, "ld_selir", V_N);
    cyc(0, 0, "ld_capir", V_N);
    cyc(0, 0, "ir_tdo0", V_N_T1);
    cyc(0, 0, "ir_tdo1", V_N);
    cyc(1, 0, "ir_tdo2", V_N);
    cyc(1, 0, "ld_ex1ir", V_N);
    cyc(0, 0, "ld_updir", V_N);
    cyc(0, 0, "extest_en", V_EN);

    // EXTEST scan: shift 1010 through the four-cell chain holding 0110
    cyc(1, 0, "ex_rti", V_EN);
    cyc(0, 0, "ex_seldr", V_EN);
    cyc(0, 0, "ex_capdr", V_CAP);
    cyc(0, 1, "ex_sh0", V_SH0);
    cyc(0, 0, "ex_sh1", V_SH1);
    cyc(0, 1, "ex_sh2", V_SH1);
    cyc(1, 0, "ex_sh3", V_SH0);
    cyc(0, 0, "ex_ex1dr", V_EN);
    cyc(0, 0, "ex_padr0", V_EN);
    cyc(1, 0, "ex_padr1", V_EN);
    cyc(1, 0, "ex_ex2dr", V_EN);
    cyc(0, 0, "ex_upddr", V_UPD);
    cyc(0, 0, "ex_rti_end", V_EN);

    // Walk to PA_DR, then five tms=1 cycles land in TLR with BYPASS active
    cyc(1, 0, "r_rti", V_EN);
    cyc(0, 0, "r_seldr", V_EN);
    cyc(1, 0, "r_capdr", V_CAP);
    cyc(0, 0, "r_ex1dr", V_EN);
    cyc(1, 0, "r_tms1_padr", V_EN);
    cyc(1, 0, "r_tms2_ex2dr", V_EN);
    cyc(1, 0, "r_tms3_upddr", V_UPD);
    cyc(1, 0, "r_tms4_seldr", V_EN);
    cyc(1, 0, "r_tms5_selir", V_EN);
    cyc(1, 0, "r_tlr", V_N);

    // BYPASS: 11001010 appears on tdo one cycle late behind a captured 0
    cyc(0, 0, "bp_tlr", V_N);
    cyc(1, 0, "bp_rti", V_N);
    cyc(0, 0, "bp_seldr", V_N);
    cyc(0, 0, "bp_capdr", V_N);
    byp_bits = 8'b1100_1010;
    byp_tdo  = 8'b0110_0101;
    for (int i = 0; i < 8; i++)
      cyc((i == 7), byp_bits[7-i], $sformatf("bp_sh%0d", i), {byp_tdo[7-i], 7'b000_0110});
    cyc(1, 0, "bp_ex1dr", V_N);
    cyc(0, 0, "bp_upddr", V_N);

    // Load BIST (011) and hold RTI for 15 cycles
    cyc(1, 0, "bi_rti", V_N);
    cyc(1, 0, "bi_seldr", V_N);
    cyc(0, 0, "bi_selir", V_N);
    cyc(0, 0, "bi_capir", V_N);
    cyc(0, 1, "bi_sh0", V_N_T1);
    cyc(0, 1, "bi_sh1", V_N);
    cyc(1, 0, "bi_sh2", V_N);
    cyc(1, 0, "bi_ex1ir", V_N);
    cyc(0, 0, "bi_updir", V_N);
    for (int i = 0; i < 15; i++)
      cyc(0, 0, $sformatf("bist_rti%0d", i), (i < 10) ? V_BIST : V_DONE);
    cyc(1, 0, "bd_rti", V_DONE);
    cyc(1, 0, "bd_seldr", V_DONE);
    cyc(0, 0, "bd_selir", V_DONE);
    cyc(0, 0, "bd_capir", V_DONE);
    cyc(1, 1, "bd_shir", V_DONE_T);
    cyc(1, 0, "bd_ex1ir", V_DONE);
    cyc(0, 0, "bd_updir", V_DONE);
    cyc(1, 0, "bd_cleared", V_N);

    // Reload BIST; leave RTI mid-run, resume, and saturate on the exit edge
    cyc(1, 0, "b2_seldr", V_N);
    cyc(0, 0, "b2_selir", V_N);
    cyc(0, 0, "b2_capir", V_N);
    cyc(0, 1, "b2_sh0", V_N_T1);
    cyc(0, 1, "b2_sh1", V_N);
    cyc(1, 0, "b2_sh2", V_N);
    cyc(1, 0, "b2_ex1ir", V_N);
    cyc(0, 0, "b2_updir", V_N);
    for (int i = 0; i < 5; i++)
      cyc((i == 4), 0, $sformatf("b2_runa%0d", i), V_BIST);
    cyc(0, 0, "b2_seldr_f", V_N);
    cyc(1, 0, "b2_capdr_f", V_N);
    cyc(1, 0, "b2_ex1dr_f", V_N);
    cyc(0, 0, "b2_upddr_f", V_N);
    for (int i = 0; i < 5; i++)
      cyc((i == 4), 0, $sformatf("b2_runb%0d", i), V_BIST);
    cyc(0, 0, "b2_done_seldr", V_DONE);
    cyc(0, 0, "b2_done_capdr", V_DONE);
    cyc(0, 1, "b2_bist_shdr", V_BSHIFT);

    // Asynchronous reset mid-SH_DR: outputs return to reset values before any edge
    rst_l = 1'b0;
    cyc(0, 1, "async_rst", V_N);
    cyc(1, 0, "rst_hold", V_N);
    rst_l = 1'b1;
    cyc(1, 0, "post_rst_tlr", V_N);

    for (int i = 0; i < 4 && sb.size() != 0; i++)
      @(negedge clock);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
# tap_controller

Test access port controller that sequences the boundary-scan (`bsr`) chain and the BILBO registers from a serial `tms`/`tdi`/`tdo` interface. It implements the 16-state IEEE 1149.1-style TAP state machine, an instruction register, and a bypass register. It also contains a BIST run counter. The block sits between the chip's test pins and the scan/BILBO cells, and drives their shift, capture, update, enable and b1/b2 controls.

## Interface
- `IR_W`, default 3: instruction register width.
- `BIST_CYCLES`, default 255: number of BIST clock cycles per run (1 to 2^16-1).
- `clock` input 1: the single clock. All state changes on its rising edge.
- `rst_l` input 1: asynchronous, active-low reset.
- `tms` input 1: test mode select, sampled on the rising edge.
- `tdi` input 1: test data in.
- `tdo` output 1: test data out.
- `bsr_scan_out` input 1: serial output of the last boundary-scan cell.
- `bsr_scan_in` output 1: serial input to the first boundary-scan cell (equals `tdi`).
- `bsr_shift` output 1: boundary-scan mux select (1 = shift, 0 = capture).
- `bsr_capture` output 1: boundary-scan flop load enable.
- `bsr_update` output 1: one-cycle update pulse.
- `bsr_en` output 1: drives boundary-scan cell outputs from the chain instead of functional data.
- `b1`, `b2` outputs 1: BILBO mode controls.
- `bist_done` output 1: sticky BIST completion flag.

## Operation
- FSM states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
- FSM transitions follow standard TAP rules, listed as tms=0 / tms=1:
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - SEL_IR: CAP_IR / TLR
  - CAP_x: SH_x / EX1_x
  - SH_x: SH_x / EX1_x
  - EX1_x: PA_x / UPD_x
  - PA_x: PA_x / EX2_x
  - EX2_x: SH_x / UPD_x
  - UPD_x: RTI / SEL_DR
- Five consecutive tms=1 cycles reach TLR from any state.
- Instruction set:
  - EXTEST = 000 and INTEST = 010: select the BSR and assert `bsr_en`.
  - SAMPLE = 001: selects the BSR; `bsr_en` = 0.
  - BIST = 011: selects the bypass register.
  - Every other code, including all-ones, is BYPASS.
- Instruction register: a shift register plus a separate active register.
  - CAP_IR loads the shift register with 0...01.
  - SH_IR shifts right, with `tdi` entering the MSB.
  - UPD_IR copies the shift register to the active register.
  - TLR forces the active register to BYPASS (all-ones).
- Bypass register: 1 bit, cleared in CAP_DR, loaded from `tdi` in SH_DR.
- `tdo`:
  - SH_IR: IR shift LSB.
  - SH_DR: `bsr_scan_out` when the BSR is selected, else the bypass bit.
  - All other states: 0.
  - `tdo` is combinational from registered state.
- BSR controls, all gated by "BSR selected":
  - `bsr_capture` = CAP_DR or SH_DR.
  - `bsr_shift` = SH_DR.
  - `bsr_update` = UPD_DR.
  - In PA_DR and EX_DR states `bsr_capture` = 0, so the chain holds.
- BILBO controls:
  - Default b1 = 1, b2 = 1 (normal).
  - Active instruction BIST and state SH_DR: b1 = 0, b2 = 0 (scan shift).
  - Active instruction BIST, state RTI, and counter below `BIST_CYCLES`: b1 = 1, b2 = 0 (pattern/signature).
- BIST counter, 16 bits:
  - Cleared in UPD_IR.
  - Increments each RTI cycle while BIST is active and the count is below `BIST_CYCLES`.
  - Saturates at `BIST_CYCLES`, which sets `bist_done`.
  - Leaving RTI freezes the count; re-entering RTI resumes it.
  - `bist_done` clears on UPD_IR or TLR.

## Timing
- Reset (`rst_l` low, asynchronous): state = TLR, active IR = all-ones, IR shift = 0...01, bypass = 0, counter = 0.
  - Output reset values: `tdo` = 0, `bsr_shift` = 0, `bsr_capture` = 0, `bsr_update` = 0, `bsr_en` = 0, b1 = 1, b2 = 1, `bist_done` = 0.
- All outputs are decoded from current state and active IR, with no extra pipeline stage.
- An output asserts in the same cycle the FSM is in its state.
- A new instruction takes effect in the cycle after UPD_IR.
- In SH_DR, `tdi` is captured on each rising edge. The first captured bit appears at `tdo` after N cycles for an N-bit DR; for bypass this is one cycle.
- Reset asserted mid-shift aborts the shift and discards IR shift contents; the active IR returns to BYPASS.
- Reaching the saturated count and leaving RTI in the same cycle still sets `bist_done`.

## Test plan
- Reset, then 5 cycles of tms=1 from random states -> state TLR, active IR = 111, b1 = 1, b2 = 1, all bsr controls 0.
- Load IR = 000 (tms 0,1,1,0,0, then shift 0,0,0 with tms=1 on the last bit, then 1,0) -> `bsr_en` = 1 from the cycle after UPD_IR; `tdo` during SH_IR shows the captured 001.
- EXTEST with a 4-cell chain, shift in 1010 -> `bsr_capture` = 1 in CAP_DR and SH_DR, `bsr_shift` = 1 only in SH_DR, a single `bsr_update` pulse in UPD_DR, and 0 in PA_DR.
- BYPASS, shift 8 bits 11001010 through DR -> `tdo` reproduces the bits delayed by 1 cycle, with a first bit of 0 (the captured value).
- BIST with `BIST_CYCLES` = 10, hold RTI for 15 cycles -> b1 = 1, b2 = 0 for exactly 10 cycles, then 1/1, and `bist_done` = 1 from cycle 10; the next UPD_IR clears it.
- Assert `rst_l` low mid-SH_DR with BIST active -> all outputs take reset values immediately and asynchronously.
